rif_timer_regs: RTL and testbench

Register-interface slave that sits directly downstream of the AHB-Lite adapter and consumes its `rif_*` request bus. Implements a small memory-mapped timer: control, reload, current value, interrupt status (W1C), scratch and ID registers, plus a prescaled down-counter and a level interrupt output. Address decode drives `rif_addr_valid` so the adapter can return an AHB ERROR for unmapped or unaligned accesses.

---
 rtl/rif_timer_pkg.sv | 56 +++++
 rtl/rif_timer_core.sv | 51 +++++
 rtl/rif_timer_regs.sv | 129 ++++++++++++
 tb/tb_rif_timer_regs.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rif_timer_pkg.sv
// Shared constants, register selector and byte-merge helper for the
// register-interface timer.
package rif_timer_pkg;

    localparam int REG_W = 32;

    localparam int OFF_CTRL    = 'h000;
    localparam int OFF_LOAD    = 'h004;
    localparam int OFF_VALUE   = 'h008;
    localparam int OFF_STATUS  = 'h00C;
    localparam int OFF_SCRATCH = 'h010;
    localparam int OFF_ID      = 'h014;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ERR_IE = 3;
    localparam int CTRL_PS_LSB = 8;
    localparam int PRESCALE_W  = 8;

    localparam int ST_EXP = 0;
    localparam int ST_ERR = 1;
    localparam int ST_W   = 2;

    localparam logic [REG_W-1:0] CTRL_MASK = 32'h0000_FF0F;

    localparam logic [REG_W-1:0] CTRL_RST    = '0;
    localparam logic [REG_W-1:0] LOAD_RST    = '0;
    localparam logic [REG_W-1:0] VALUE_RST   = '0;
    localparam logic [REG_W-1:0] SCRATCH_RST = '0;
    localparam logic [ST_W-1:0]  STATUS_RST  = '0;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_LOAD,
        SEL_VALUE,
        SEL_STATUS,
        SEL_SCRATCH,
        SEL_ID
    } reg_sel_e;

    function automatic logic [REG_W-1:0] byte_merge(
        input logic [REG_W-1:0]   cur,
        input logic [REG_W-1:0]   wdat,
        input logic [REG_W/8-1:0] strb
    );
        logic [REG_W-1:0] res;
        res = cur;
        for (int i = 0; i < REG_W/8; i++) begin
            if (strb[i]) res[i*8 +: 8] = wdat[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rif_timer_core.sv
// Prescaler and down-counter; a load strobe overrides any tick in the
// same cycle.
module rif_timer_core
    import rif_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  psc_clr,
    input  logic                  load,
    input  logic [REG_W-1:0]      load_value,
    input  logic [REG_W-1:0]      reload_value,
    output logic [REG_W-1:0]      value,
    output logic                  expire,
    output logic                  en_clear
);

    logic [PRESCALE_W-1:0] psc;
    logic                  psc_hit;
    logic                  tick;

    assign psc_hit  = (psc == prescale);
    assign tick     = en && psc_hit && !load;
    assign expire   = tick && (value <= 32'd1);
    assign en_clear = expire && !auto_reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
        end else if (load || psc_clr) begin
            psc <= '0;
        end else if (en) begin
            psc <= psc_hit ? '0 : psc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= VALUE_RST;
        end else if (load) begin
            value <= load_value;
        end else if (expire) begin
            value <= auto_reload ? reload_value : '0;
        end else if (tick) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/rif_timer_regs.sv
// Timer register bank on the rif_* bus: decode, byte-wise writes,
// W1C status and the level interrupt.
module rif_timer_regs
    import rif_timer_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter int          BYTE_COUNT = DATA_WIDTH/8,
    parameter logic [31:0] ID_VALUE   = 32'h5449_0001
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] rif_addr,
    output logic                  rif_addr_valid,
    input  logic                  rif_wr_req,
    input  logic                  rif_rd_req,
    input  logic [BYTE_COUNT-1:0] rif_wstrb,
    input  logic [DATA_WIDTH-1:0] rif_wdata,
    output logic [DATA_WIDTH-1:0] rif_rdata,
    output logic                  irq
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $fatal(1, "rif_timer_regs: only DATA_WIDTH=32 is supported");
    end

    reg_sel_e         sel;
    logic [REG_W-1:0] ctrl;
    logic [REG_W-1:0] load;
    logic [REG_W-1:0] scratch;
    logic [ST_W-1:0]  status;
    logic [REG_W-1:0] value;
    logic [REG_W-1:0] ctrl_wval;
    logic [REG_W-1:0] load_wval;
    logic [ST_W-1:0]  w1c;
    logic [ST_W-1:0]  hw_set;
    logic             wr;
    logic             ctrl_we;
    logic             load_we;
    logic             en_set;
    logic             expire;
    logic             en_clear;

    always_comb begin
        sel = SEL_NONE;
        case (rif_addr)
            ADDR_WIDTH'(OFF_CTRL):    sel = SEL_CTRL;
            ADDR_WIDTH'(OFF_LOAD):    sel = SEL_LOAD;
            ADDR_WIDTH'(OFF_VALUE):   sel = SEL_VALUE;
            ADDR_WIDTH'(OFF_STATUS):  sel = SEL_STATUS;
            ADDR_WIDTH'(OFF_SCRATCH): sel = SEL_SCRATCH;
            ADDR_WIDTH'(OFF_ID):      sel = SEL_ID;
            default:                  sel = SEL_NONE;
        endcase
    end

    // Offsets are word-aligned, so an exact match implies alignment.
    assign rif_addr_valid = (sel != SEL_NONE);

    assign wr        = rif_wr_req && rif_addr_valid;
    assign ctrl_wval = byte_merge(ctrl, rif_wdata, rif_wstrb) & CTRL_MASK;
    assign load_wval = byte_merge(load, rif_wdata, rif_wstrb);
    assign ctrl_we   = wr && (sel == SEL_CTRL);
    assign load_we   = wr && (sel == SEL_LOAD) && (|rif_wstrb);
    assign en_set    = ctrl_we && !ctrl[CTRL_EN] && ctrl_wval[CTRL_EN];

    assign w1c = (wr && (sel == SEL_STATUS) && rif_wstrb[0])
               ? rif_wdata[ST_W-1:0] : '0;

    assign hw_set[ST_EXP] = expire;
    assign hw_set[ST_ERR] = (rif_wr_req || rif_rd_req) && !rif_addr_valid;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ctrl <= CTRL_RST;
        end else begin
            if (ctrl_we)  ctrl <= ctrl_wval;
            if (en_clear) ctrl[CTRL_EN] <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            load    <= LOAD_RST;
            scratch <= SCRATCH_RST;
            status  <= STATUS_RST;
        end else begin
            if (load_we) load <= load_wval;
            if (wr && (sel == SEL_SCRATCH)) begin
                scratch <= byte_merge(scratch, rif_wdata, rif_wstrb);
            end
            status <= (status & ~w1c) | hw_set;
        end
    end

    rif_timer_core u_core (
        .clk          (HCLK),
        .rst          (HRESET),
        .en           (ctrl[CTRL_EN]),
        .auto_reload  (ctrl[CTRL_AUTO]),
        .prescale     (ctrl[CTRL_PS_LSB +: PRESCALE_W]),
        .psc_clr      (en_set),
        .load         (load_we),
        .load_value   (load_wval),
        .reload_value (load),
        .value        (value),
        .expire       (expire),
        .en_clear     (en_clear)
    );

    always_comb begin
        rif_rdata = '0;
        if (rif_rd_req) begin
            case (sel)
                SEL_CTRL:    rif_rdata = ctrl;
                SEL_LOAD:    rif_rdata = load;
                SEL_VALUE:   rif_rdata = value;
                SEL_STATUS:  rif_rdata = {{(REG_W-ST_W){1'b0}}, status};
                SEL_SCRATCH: rif_rdata = scratch;
                SEL_ID:      rif_rdata = ID_VALUE;
                default:     rif_rdata = '0;
            endcase
        end
    end

    assign irq = (status[ST_EXP] && ctrl[CTRL_IRQ_EN])
              || (status[ST_ERR] && ctrl[CTRL_ERR_IE]);

endmodule

// File: tb/tb_rif_timer_regs.sv
// Directed and randomized bench for rif_timer_regs against a
// cycle-level behavioural model of the timer registers.
module tb_rif_timer_regs;

    localparam logic [31:0] ID = 32'h5449_0001;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] rif_addr;
    logic        rif_addr_valid;
    logic        rif_wr_req;
    logic        rif_rd_req;
    logic [3:0]  rif_wstrb;
    logic [31:0] rif_wdata;
    logic [31:0] rif_rdata;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [31:0] m_ctrl, m_load, m_value, m_scr;
    logic [1:0]  m_stat;
    int          m_psc;

    logic [31:0] rd_val;
    logic        av_obs;
    logic        irq_obs;

    rif_timer_regs dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .rif_addr       (rif_addr),
        .rif_addr_valid (rif_addr_valid),
        .rif_wr_req     (rif_wr_req),
        .rif_rd_req     (rif_rd_req),
        .rif_wstrb      (rif_wstrb),
        .rif_wdata      (rif_wdata),
        .rif_rdata      (rif_rdata),
        .irq            (irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid(input logic [11:0] a);
        return a == 12'h000 || a == 12'h004 || a == 12'h008 ||
               a == 12'h00C || a == 12'h010 || a == 12'h014;
    endfunction

    function automatic logic [31:0] m_rdata(input bit rd,
                                            input logic [11:0] a);
        if (!rd || !m_valid(a)) return 32'h0;
        case (a)
            12'h000: return m_ctrl;
            12'h004: return m_load;
            12'h008: return m_value;
            12'h00C: return {30'h0, m_stat};
            12'h010: return m_scr;
            default: return ID;
        endcase
    endfunction

    function automatic logic m_irq();
        return (m_stat[0] & m_ctrl[2]) | (m_stat[1] & m_ctrl[3]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    task automatic m_reset();
        m_ctrl = 0; m_load = 0; m_value = 0; m_scr = 0;
        m_stat = 0; m_psc = 0;
    endtask

    // Next state of the whole register file after one clock.
    task automatic m_step(input bit wr, input bit rd,
                          input logic [11:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        bit v = m_valid(a);
        bit tick, exp_set = 0, en_clr = 0;
        logic [31:0] nctrl = m_ctrl, nload = m_load;
        logic [31:0] nval = m_value, nscr = m_scr;
        logic [1:0]  nstat = m_stat;
        int npsc = m_psc;
        int ps = int'(m_ctrl[15:8]);
        tick = m_ctrl[0] && (m_psc == ps);
        if (m_ctrl[0]) npsc = tick ? 0 : (m_psc + 1) % 256;
        if (tick) begin
            if (m_value > 1) nval = m_value - 1;
            else begin
                exp_set = 1;
                if (m_ctrl[1]) nval = m_load;
                else begin nval = 0; en_clr = 1; end
            end
        end
        if (wr && v) begin
            case (a)
                12'h000: begin
                    nctrl = merge(m_ctrl, d, s) & 32'h0000FF0F;
                    if (!m_ctrl[0] && nctrl[0]) npsc = 0;
                end
                12'h004: if (s != 0) begin
                    nload = merge(m_load, d, s);
                    nval = nload; npsc = 0;
                    exp_set = 0; en_clr = 0;
                end
                12'h00C: if (s[0]) nstat = m_stat & ~d[1:0];
                12'h010: nscr = merge(m_scr, d, s);
                default: ;
            endcase
        end
        if (en_clr) nctrl[0] = 1'b0;
        nstat[0] = nstat[0] | exp_set;
        nstat[1] = nstat[1] | ((wr || rd) && !v);
        m_ctrl = nctrl; m_load = nload; m_value = nval;
        m_scr = nscr; m_stat = nstat; m_psc = npsc;
    endtask

    task automatic cyc(input bit wr, input bit rd, input logic [11:0] a,
                       input logic [3:0] s, input logic [31:0] d);
        @(negedge HCLK);
        rif_wr_req = wr; rif_rd_req = rd; rif_addr = a;
        rif_wstrb = s; rif_wdata = d;
        #1;
        chk("addr_valid", {31'h0, rif_addr_valid}, {31'h0, m_valid(a)});
        chk("rdata", rif_rdata, m_rdata(rd, a));
        chk("irq", {31'h0, irq}, {31'h0, m_irq()});
        rd_val = rif_rdata; av_obs = rif_addr_valid; irq_obs = irq;
        m_step(wr, rd, a, s, d);
    endtask

    task automatic wr32(input logic [11:0] a, input logic [31:0] d);
        cyc(1, 0, a, 4'hF, d);
    endtask

    task automatic rd32(input logic [11:0] a);
        cyc(0, 1, a, 4'h0, 32'h0);
    endtask

    task automatic idle();
        cyc(0, 0, 12'h0, 4'h0, 32'h0);
    endtask

    logic [31:0] exp_q[$];
    logic [11:0] pick[10];

    initial begin
        HRESET = 1'b1; rif_wr_req = 0; rif_rd_req = 0;
        rif_addr = 0; rif_wstrb = 0; rif_wdata = 0;
        m_reset();
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;

        // reset values
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ID};
        for (int i = 0; i < 6; i++) begin
            rd32(12'(i * 4));
            chk("reset_read", rd_val, exp_q[i]);
        end
        chk("reset_irq", {31'h0, irq_obs}, 32'h0);

        // partial-strobe scratch write
        cyc(1, 0, 12'h010, 4'b0001, 32'hA5A5A5A5);
        rd32(12'h010);
        chk("scratch_strb", rd_val, 32'h000000A5);

        // auto-reload, prescale 0
        wr32(12'h004, 32'd3);
        wr32(12'h000, 32'h07);
        exp_q = '{32'd3, 32'd2, 32'd1, 32'd3};
        for (int i = 0; i < 4; i++) begin
            rd32(12'h008);
            chk("auto_value", rd_val, exp_q[i]);
        end
        chk("auto_irq", {31'h0, irq_obs}, 32'h1);
        wr32(12'h000, 32'h0);
        rd32(12'h00C);
        chk("auto_exp", rd_val, 32'h1);
        wr32(12'h00C, 32'h3);

        // one-shot, prescale 2
        wr32(12'h004, 32'd2);
        wr32(12'h000, 32'h0201);
        exp_q = '{2, 2, 2, 1, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            rd32(12'h008);
            chk("oneshot_value", rd_val, exp_q[i]);
        end
        rd32(12'h000);
        chk("oneshot_ctrl", rd_val, 32'h0200);
        rd32(12'h00C);
        chk("oneshot_exp", rd_val, 32'h1);

        // invalid accesses
        wr32(12'h00C, 32'h3);
        wr32(12'h000, 32'h08);
        rd32(12'h006);
        chk("unaligned_valid", {31'h0, av_obs}, 32'h0);
        wr32(12'h100, 32'hFFFFFFFF);
        chk("unmapped_valid", {31'h0, av_obs}, 32'h0);
        rd32(12'h00C);
        chk("err_status", rd_val, 32'h2);
        chk("err_irq", {31'h0, irq_obs}, 32'h1);
        wr32(12'h00C, 32'h2);
        rd32(12'h00C);
        chk("err_clear", rd_val, 32'h0);
        chk("err_irq_clear", {31'h0, irq_obs}, 32'h0);

        // W1C of EXP racing a new expiry
        wr32(12'h004, 32'd1);
        wr32(12'h000, 32'h03);
        wr32(12'h00C, 32'h1);
        wr32(12'h000, 32'h0);
        rd32(12'h00C);
        chk("w1c_race", rd_val, 32'h1);
        wr32(12'h00C, 32'h3);

        // asynchronous reset mid-count
        wr32(12'h004, 32'd100);
        wr32(12'h000, 32'h0F);
        repeat (5) idle();
        @(negedge HCLK);
        rif_wr_req = 0; rif_rd_req = 0;
        #2 HRESET = 1'b1;
        m_reset();
        #1;
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        rd32(12'h008);
        chk("rst_value", rd_val, 32'h0);
        rd32(12'h000);
        chk("rst_ctrl", rd_val, 32'h0);

        // randomized traffic
        pick = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                 12'h014, 12'h006, 12'h100, 12'h018, 12'hFFC};
        for (int i = 0; i < 1500; i++) begin
            int op = $urandom_range(0, 3);
            logic [11:0] a = pick[$urandom_range(0, 9)];
            logic [3:0]  s = 4'($urandom_range(0, 15));
            logic [31:0] d = $urandom;
            if (a == 12'h000) d[15:8] = 8'($urandom_range(0, 3));
            if (a == 12'h004 && $urandom_range(0, 3) != 0)
                d = 32'($urandom_range(0, 6));
            if (a == 12'h004 || a == 12'h000)
                s[0] = ($urandom_range(0, 3) != 0);
            cyc(op == 2, op == 1 || op == 3, a, s, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
